// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: decoder states, error codes,
// frame field offsets and the checksum helper.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESP_LOW_WAIT,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_DONE
    } state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_NO_RESP   = 3'd1;
    localparam logic [2:0] ERR_RESP_LOW  = 3'd2;
    localparam logic [2:0] ERR_RESP_HIGH = 3'd3;
    localparam logic [2:0] ERR_BIT_LOW   = 3'd4;
    localparam logic [2:0] ERR_BIT_HIGH  = 3'd5;

    localparam int FRAME_W    = 40;
    localparam int RH_INT_LSB = 32;
    localparam int RH_DEC_LSB = 24;
    localparam int T_INT_LSB  = 16;
    localparam int T_DEC_LSB  = 8;
    localparam int CSUM_LSB   = 0;

    // Sum of the four data bytes, low byte compared to the checksum byte
    function automatic logic crc_ok_f(input logic [FRAME_W-1:0] f);
        logic [9:0] sum;
        sum = {2'b00, f[RH_INT_LSB +: 8]}
            + {2'b00, f[RH_DEC_LSB +: 8]}
            + {2'b00, f[T_INT_LSB +: 8]}
            + {2'b00, f[T_DEC_LSB +: 8]};
        return sum[7:0] == f[CSUM_LSB +: 8];
    endfunction

endpackage

// File: rtl/dht11_input_filter.sv
// Two-flop synchroniser followed by a stability filter.
// The filtered level idles high and follows the pin after FILT_CYC stable cycles.
module dht11_input_filter #(
    parameter int FILT_CYC = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic lvl_o
);

    localparam int FW = $clog2(FILT_CYC + 1);

    logic [1:0]    sync_q;
    logic          lvl_q, lvl_d;
    logic [FW-1:0] stab_q, stab_d;

    // Synchroniser, filtered level and stability counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            lvl_q  <= 1'b1;
            stab_q <= '0;
        end else begin
            sync_q <= {sync_q[0], din_i};
            lvl_q  <= lvl_d;
            stab_q <= stab_d;
        end
    end

    // Count consecutive cycles that disagree with the current level
    always_comb begin
        lvl_d  = lvl_q;
        stab_d = '0;
        if (sync_q[1] != lvl_q) begin
            if (stab_q == FW'(FILT_CYC - 1)) begin
                lvl_d = sync_q[1];
            end else begin
                stab_d = stab_q + FW'(1);
            end
        end
    end

    assign lvl_o = lvl_q;

endmodule

// File: rtl/dht11_pulse_decoder.sv
// DHT11 receive decoder: response preamble check, 40-bit
// pulse-width decode, checksum verdict and error reporting.
module dht11_pulse_decoder
    import dht11_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int FILT_CYC    = 4,
    parameter int THRESH_CYC  = 2500,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_in,
    input  logic        arm,
    output logic        busy,
    output logic [39:0] frame,
    output logic        frame_valid,
    output logic        crc_ok,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [5:0]  bit_count
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] THR = CW'(THRESH_CYC);

    if (CLK_HZ < 1_000_000) begin : g_clk_chk
        $error("CLK_HZ below 1 MHz cannot resolve DHT11 pulses");
    end

    logic         lvl, lvl_prev_q, fall, rise, tmo;
    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [39:0]  shift_q, shift_d, frame_q, frame_d;
    logic [5:0]   bitc_q, bitc_d;
    logic         crc_q, crc_d, fv_q, fv_d, err_q, err_d;
    logic [2:0]   code_q, code_d;

    dht11_input_filter #(.FILT_CYC(FILT_CYC)) u_filt (
        .clk    (clk),
        .reset_n(reset_n),
        .din_i  (data_in),
        .lvl_o  (lvl)
    );

    assign fall = lvl_prev_q & ~lvl;
    assign rise = ~lvl_prev_q & lvl;
    assign tmo  = (cnt_q == TMO);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            lvl_prev_q <= 1'b1;
            cnt_q      <= '0;
            shift_q    <= '0;
            bitc_q     <= '0;
            frame_q    <= '0;
            crc_q      <= 1'b0;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            lvl_prev_q <= lvl;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bitc_q     <= bitc_d;
            frame_q    <= frame_d;
            crc_q      <= crc_d;
            fv_q       <= fv_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    // Next state: an edge takes priority over a timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:          if (arm) state_d = ST_RESP_LOW_WAIT;
            ST_RESP_LOW_WAIT: if (fall) state_d = ST_RESP_LOW;
                              else if (tmo) state_d = ST_IDLE;
            ST_RESP_LOW:      if (rise) state_d = ST_RESP_HIGH;
                              else if (tmo) state_d = ST_IDLE;
            ST_RESP_HIGH:     if (fall) state_d = ST_BIT_LOW;
                              else if (tmo) state_d = ST_IDLE;
            ST_BIT_LOW:       if (rise) state_d = ST_BIT_HIGH;
                              else if (tmo) state_d = ST_IDLE;
            ST_BIT_HIGH:
                if (fall) begin
                    state_d = (bitc_q == 6'(FRAME_W - 1)) ? ST_DONE : ST_BIT_LOW;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                end
            ST_DONE:          state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Phase counter, shift register, frame and error outputs
    always_comb begin
        if (state_q == ST_IDLE || state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = tmo ? cnt_q : cnt_q + CW'(1);
        end
        shift_d = shift_q;
        bitc_d  = bitc_q;
        frame_d = frame_q;
        crc_d   = crc_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    shift_d = '0;
                    bitc_d  = '0;
                end
            end
            ST_RESP_LOW_WAIT: begin
                if (!fall && tmo) begin
                    err_d  = 1'b1;
                    code_d = ERR_NO_RESP;
                end
            end
            ST_RESP_LOW: begin
                if (!rise && tmo) begin
                    err_d  = 1'b1;
                    code_d = ERR_RESP_LOW;
                end
            end
            ST_RESP_HIGH: begin
                if (!fall && tmo) begin
                    err_d  = 1'b1;
                    code_d = ERR_RESP_HIGH;
                end
            end
            ST_BIT_LOW: begin
                if (!rise && tmo) begin
                    err_d  = 1'b1;
                    code_d = ERR_BIT_LOW;
                end
            end
            ST_BIT_HIGH: begin
                if (fall) begin
                    shift_d = {shift_q[38:0], (cnt_q > THR)};
                    bitc_d  = bitc_q + 6'd1;
                end else if (tmo) begin
                    err_d  = 1'b1;
                    code_d = ERR_BIT_HIGH;
                end
            end
            ST_DONE: begin
                frame_d = shift_q;
                crc_d   = crc_ok_f(shift_q);
                fv_d    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign frame       = frame_q;
    assign frame_valid = fv_q;
    assign crc_ok      = crc_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign bit_count   = bitc_q;

endmodule

// File: tb/tb_dht11_pulse_decoder.sv
// Directed bench for dht11_pulse_decoder, run at 1 MHz so one
// cycle equals one microsecond of DHT11 line time.
`timescale 1ns/1ps
module tb_dht11_pulse_decoder;

    localparam int FILT = 4;
    localparam int THR  = 50;
    localparam int TMO  = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_in = 1'b1;
    logic        arm = 1'b0;
    logic        busy;
    logic [39:0] frame;
    logic        frame_valid;
    logic        crc_ok;
    logic        err;
    logic [2:0]  err_code;
    logic [5:0]  bit_count;

    dht11_pulse_decoder #(
        .CLK_HZ     (1_000_000),
        .FILT_CYC   (FILT),
        .THRESH_CYC (THR),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .arm        (arm),
        .busy       (busy),
        .frame      (frame),
        .frame_valid(frame_valid),
        .crc_ok     (crc_ok),
        .err        (err),
        .err_code   (err_code),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    int fv_cyc = 0;
    int err_cyc = 0;
    int fall_cyc = 0;
    logic [39:0] fv_frame;
    logic        fv_crc;
    logic        fv_busy;
    logic [5:0]  fv_bits;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt   <= fv_cnt + 1;
            fv_frame <= frame;
            fv_crc   <= crc_ok;
            fv_busy  <= busy;
            fv_bits  <= bit_count;
            fv_cyc   <= cyc;
        end
        if (err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        data_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic hi(input int n, input bit g);
        if (g) begin
            hold(1'b1, n / 2);
            hold(1'b0, 2);
            hold(1'b1, n - n / 2 - 2);
        end else begin
            hold(1'b1, n);
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Sensor model: response preamble then 40 bits, MSB first
    task automatic send_frame(input logic [39:0] f, input bit g,
                              input int stop_at, input bit stop_rst,
                              input int arm_at);
        hold(1'b0, 80);
        hi(80, g);
        for (int i = 0; i < 40; i++) begin
            int h;
            h = f[39 - i] ? 70 : 27;
            if (stop_at == i && stop_rst) begin
                hold(1'b0, 20);
                reset_n = 1'b0;
                return;
            end
            hold(1'b0, 50);
            if (stop_at == i) begin
                hold(1'b1, 250);
                return;
            end
            if (arm_at == i) begin
                hold(1'b1, 10);
                arm = 1'b1;
                hold(1'b1, 1);
                arm = 1'b0;
                hold(1'b1, h - 11);
            end else begin
                hi(h, g);
            end
        end
        fall_cyc = cyc;
        hold(1'b0, 50);
        hold(1'b1, 20);
    endtask

    task automatic wait_fv(input int n0);
        int k;
        k = 0;
        while (fv_cnt == n0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("fv_seen", 64'(fv_cnt > n0), 64'd1);
    endtask

    task automatic wait_err(input int n0);
        int k;
        k = 0;
        while (err_cnt == n0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("err_seen", 64'(err_cnt > n0), 64'd1);
    endtask

    initial begin
        int a;
        repeat (4) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame", 64'(frame), 64'd0);
        check("rst_fv", 64'(frame_valid), 64'd0);
        check("rst_crc", 64'(crc_ok), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_code", 64'(err_code), 64'd0);
        check("rst_bits", 64'(bit_count), 64'd0);
        reset_n = 1'b1;
        hold(1'b1, 20);

        // Nominal frame
        do_arm();
        check("busy_after_arm", 64'(busy), 64'd1);
        send_frame(40'h320019004B, 1'b0, -1, 1'b0, -1);
        wait_fv(0);
        check("nom_fv_cnt", 64'(fv_cnt), 64'd1);
        check("nom_frame", 64'(fv_frame), 64'h320019004B);
        check("nom_crc", 64'(fv_crc), 64'd1);
        check("nom_bits", 64'(fv_bits), 64'd40);
        check("nom_busy_low", 64'(fv_busy), 64'd0);
        check("nom_fv_lat", 64'(fv_cyc - fall_cyc), 64'(2 + FILT + 2));
        check("nom_no_err", 64'(err_cnt), 64'd0);

        // Bad checksum still reported
        do_arm();
        send_frame(40'h320019004C, 1'b0, -1, 1'b0, -1);
        wait_fv(1);
        check("bad_frame", 64'(fv_frame), 64'h320019004C);
        check("bad_crc", 64'(fv_crc), 64'd0);

        // No sensor response
        a = cyc;
        do_arm();
        wait_err(0);
        check("nr_lat", 64'(err_cyc - a >= TMO + 1 && err_cyc - a <= TMO + 8),
              64'd1);
        check("nr_code", 64'(err_code), 64'd1);
        check("nr_frame", 64'(frame), 64'h320019004C);
        check("nr_crc", 64'(crc_ok), 64'd0);
        check("nr_busy", 64'(busy), 64'd0);

        // Stuck high during bit 12
        do_arm();
        send_frame(40'h320019004B, 1'b0, 11, 1'b0, -1);
        wait_err(1);
        check("stuck_code", 64'(err_code), 64'd5);
        check("stuck_bits", 64'(bit_count), 64'd11);
        check("stuck_no_fv", 64'(fv_cnt), 64'd2);
        hold(1'b1, 20);

        // Glitches in every high phase
        do_arm();
        send_frame(40'h320019004B, 1'b1, -1, 1'b0, -1);
        wait_fv(2);
        check("gl_frame", 64'(fv_frame), 64'h320019004B);
        check("gl_crc", 64'(fv_crc), 64'd1);

        // Arm pulsed while busy is ignored
        do_arm();
        send_frame(40'h0A051C032E, 1'b0, -1, 1'b0, 5);
        wait_fv(3);
        check("ab_frame", 64'(fv_frame), 64'h0A051C032E);
        check("ab_crc", 64'(fv_crc), 64'd1);
        check("ab_no_err", 64'(err_cnt), 64'd2);

        // Reset at bit 20
        do_arm();
        send_frame(40'h320019004B, 1'b0, 19, 1'b1, -1);
        #1;
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_frame", 64'(frame), 64'd0);
        check("mr_crc", 64'(crc_ok), 64'd0);
        check("mr_code", 64'(err_code), 64'd0);
        check("mr_bits", 64'(bit_count), 64'd0);
        check("mr_err", 64'(err), 64'd0);
        repeat (3) @(negedge clk);
        data_in = 1'b1;
        reset_n = 1'b1;
        hold(1'b1, 20);
        check("mr_no_err", 64'(err_cnt), 64'd2);
        do_arm();
        send_frame(40'h320019004B, 1'b0, -1, 1'b0, -1);
        wait_fv(4);
        check("mr2_frame", 64'(fv_frame), 64'h320019004B);
        check("mr2_crc", 64'(fv_crc), 64'd1);
        check("mr2_bits", 64'(fv_bits), 64'd40);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dht11_pulse_decoder.md
# dht11_pulse_decoder

Receive-side decoder for the DHT11 single-wire protocol. It sits between the bidirectional data pin and the DHT11 Avalon-MM register block. After the register block finishes the host start pulse and releases the line, it pulses `arm`. This block then synchronises and deglitches the pin, checks the sensor response preamble, and decodes the 40 data bits by high-pulse width. It returns one 40-bit frame with a checksum verdict, or an error code.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, clock frequency; all cycle counts below assume this value.
- `FILT_CYC`, 4, cycles the synchronised input must be stable before the filtered level changes.
- `THRESH_CYC`, 2500, high-pulse width threshold (50 us). Width > `THRESH_CYC` decodes as 1; width ≤ `THRESH_CYC` decodes as 0.
- `TIMEOUT_CYC`, 10000, maximum duration (200 us) of any single phase before an error is raised.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  raw pin level, asynchronous to `clk`.
- `arm`  in  1  one-cycle start request; honoured only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `frame`  out  40  last decoded frame, MSB first: `[39:32]` RH int, `[31:24]` RH dec, `[23:16]` T int, `[15:8]` T dec, `[7:0]` checksum.
- `frame_valid`  out  1  one-cycle pulse when `frame` is updated.
- `crc_ok`  out  1  checksum verdict for the current `frame`; updated together with it.
- `err`  out  1  one-cycle pulse on an aborted transfer.
- `err_code`  out  3  cause of the last error; holds its value until the next `err`.
- `bit_count`  out  6  bits decoded in the current transfer, 0..40.

## Operation
- Input path: 2-flop synchroniser, then the stability filter. The filtered level (`lvl`) resets to 1 (the line idles high).
- Edge detect runs on `lvl` only; the raw pin is never sampled directly.
- Phase counter `cnt`: width is `$clog2(TIMEOUT_CYC+1)`. It clears on every state transition and saturates at `TIMEOUT_CYC`.
- State machine:
  - IDLE: on `arm`, clear `cnt`, `bit_count` and the shift register, then go to RESP_LOW_WAIT.
  - RESP_LOW_WAIT: on a fall of `lvl`, go to RESP_LOW. On timeout, error code 1 (no response).
  - RESP_LOW: on a rise, go to RESP_HIGH. On timeout, error code 2.
  - RESP_HIGH: on a fall, go to BIT_LOW. On timeout, error code 3.
  - BIT_LOW: on a rise, go to BIT_HIGH. On timeout, error code 4.
  - BIT_HIGH: on a fall, shift in (`cnt` > `THRESH_CYC`) and increment `bit_count`. If this was the 40th bit, go to DONE; otherwise go to BIT_LOW. On timeout, error code 5.
  - DONE: load `frame` from the shift register, compute `crc_ok`, pulse `frame_valid`, return to IDLE.
- Error path: pulse `err`, load `err_code`, return to IDLE. `frame` and `crc_ok` are left unchanged.
- Checksum: `crc_ok` = (`frame[39:32]` + `[31:24]` + `[23:16]` + `[15:8]`) mod 256 == `frame[7:0]`. Use a 10-bit sum, then compare the low 8 bits.
- A frame with a bad checksum still pulses `frame_valid`, with `crc_ok`=0. Discarding it is the consumer's decision.
- Simultaneous timeout and edge in the same cycle: the edge wins.
- `arm` while `busy`: ignored, with no side effects.
- `reset_n` low mid-transfer: everything returns to reset values immediately; no `err` pulse is emitted.

## Timing
- Reset values: `busy`=0, `frame`=0, `frame_valid`=0, `crc_ok`=0, `err`=0, `err_code`=0, `bit_count`=0.
- Pin-to-`lvl` latency: 2 + `FILT_CYC` cycles. Measured pulse widths are therefore offset equally at both edges and need no correction.
- `busy` rises in the cycle after `arm`.
- `frame_valid` is asserted 2 cycles after the filtered fall that ends bit 40; `busy` drops in the same cycle.
- `err` is asserted in the cycle after `cnt` reaches `TIMEOUT_CYC`.
- Outputs are registered; the block is combinationally transparent to nothing.

## Structure
- Shared package `dht11_pkg`: state enum, error code constants (`ERR_NO_RESP`=1 … `ERR_BIT_HIGH`=5), and frame field offsets. The register block uses the same offsets for temperature extraction.
- One sub-module, `dht11_input_filter` (synchroniser plus stability filter, parameter `FILT_CYC`). It is reused for any future single-wire sensor.

## Test plan
- Nominal: after `arm`, the sensor model drives 80 us low, 80 us high, then frame `0x32_00_19_00_4B` (0 = 50 us low + 27 us high; 1 = 50 us low + 70 us high) -> one `frame_valid`, `frame`=`0x320019004B`, `crc_ok`=1, `bit_count`=40.
- Bad checksum: same frame with last byte `0x4C` -> `frame_valid`, `crc_ok`=0.
- No sensor: line held high after `arm` -> `err` at 10000 cycles after the 2+`FILT_CYC` delay, `err_code`=1, `frame` unchanged.
- Stuck high in bit 12: high pulse of 250 us -> `err_code`=5, `bit_count`=11.
- Glitch immunity: 2-cycle low spikes injected into every high phase of the nominal frame -> identical `frame` and `crc_ok`=1.
- Protocol edges: `arm` pulsed while `busy` -> no restart. `reset_n` asserted at bit 20 -> all outputs return to reset values, no `err`, and a following `arm` decodes normally.
